debounce_latch_driver: RTL

DEBOUNCE_LATCH_DRIVER -- requirements
Module: debounce_latch_driver

---
 rtl/debounce_latch_driver.sv | 117 +++++++++++
 1 files changed

// File: rtl/debounce_latch_driver.sv
// Debounces a bouncy level and drives a transparent D latch. The data is
// presented one cycle ahead of a fixed-width enable strobe and held until after it.
module debounce_latch_driver #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned EN_WIDTH   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D_raw,
    output logic D,
    output logic En,
    output logic Busy
);

    localparam int unsigned MAX_CNT = (STABLE_CNT > EN_WIDTH) ? STABLE_CNT : EN_WIDTH;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] EN_V     = CNT_W'(EN_WIDTH);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SETUP = 2'd2,
        PULSE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             cand_q, cand_d;
    logic             d_q, d_d;
    logic             en_q, en_d;

    // The raw input is only ever seen through the two-flop synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= D_raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 1'b0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        d_d     = d_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (sync2_q != d_q) begin
                    cand_d  = sync2_q;
                    cnt_d   = ONE_V;
                    state_d = COUNT;
                end else begin
                    cnt_d = '0;
                end
            end
            COUNT: begin
                // Any disagreement with the candidate means it was a bounce.
                if (sync2_q != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == STABLE_V) begin
                    d_d     = cand_q;
                    cnt_d   = '0;
                    state_d = SETUP;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                cnt_d   = ONE_V;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == EN_V) begin
                    en_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end
            default: begin
                cnt_d   = '0;
                en_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign D    = d_q;
    assign En   = en_q;
    assign Busy = (state_q != IDLE);

endmodule
